// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller bundle; perf ports under PIPE_PERF_CNT_EN
interface pipe_hazard_ctrl_if;
    logic        rdy_in;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        branch_or_not_ex;
    logic [31:0] branch_address_ex;
    logic        ld_in_ex;
    logic [4:0]  ld_rd_ex;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [5:0]  stall;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect_addr;
    logic        err_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    // master is the hazard controller, slave is the pipeline it steers
    modport master (
        input  rdy_in, stallreq_if, stallreq_mem, branch_or_not_ex, branch_address_ex,
               ld_in_ex, ld_rd_ex, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output stall, flush_if_id, flush_id_ex, pc_redirect_valid, pc_redirect_addr,
               err_timeout
`ifdef PIPE_PERF_CNT_EN
        , output perf_flush_cnt, perf_stall_cnt
`endif
    );

    modport slave (
        output rdy_in, stallreq_if, stallreq_mem, branch_or_not_ex, branch_address_ex,
               ld_in_ex, ld_rd_ex, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  stall, flush_if_id, flush_id_ex, pc_redirect_valid, pc_redirect_addr,
               err_timeout
`ifdef PIPE_PERF_CNT_EN
        , input perf_flush_cnt, perf_stall_cnt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/redirect sequencer with MEM-wait watchdog
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_in,
    input  logic               rst_in,
    pipe_hazard_ctrl_if.master hz
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic {RUN, REDIR_PEND} state_t;

    state_t        fsm, fsm_nxt;
    logic [31:0]   pend_addr, pend_nxt;
    logic [CW-1:0] wait_cnt;
    logic          err_q;
    logic          load_use;

    assign load_use = hz.ld_in_ex && (hz.ld_rd_ex != 5'd0) &&
                      ((hz.id_rs1_used && (hz.id_rs1 == hz.ld_rd_ex)) ||
                       (hz.id_rs2_used && (hz.id_rs2 == hz.ld_rd_ex)));

    always_comb begin
        hz.stall             = 6'b000000;
        hz.flush_if_id       = 1'b0;
        hz.flush_id_ex       = 1'b0;
        hz.pc_redirect_valid = 1'b0;
        hz.pc_redirect_addr  = 32'h0;
        fsm_nxt              = fsm;
        pend_nxt             = pend_addr;
        if (!rst_in || !hz.rdy_in) begin
            hz.stall = 6'b111111;
        end else if (hz.stallreq_mem) begin
            // EX is held, so a resolved branch simply re-presents once MEM releases
            hz.stall = 6'b011111;
        end else if (fsm == RUN && hz.branch_or_not_ex && !hz.stallreq_if) begin
            hz.pc_redirect_valid = 1'b1;
            hz.pc_redirect_addr  = hz.branch_address_ex;
            hz.flush_if_id       = 1'b1;
            hz.flush_id_ex       = 1'b1;
        end else if (fsm == RUN && hz.branch_or_not_ex) begin
            pend_nxt       = hz.branch_address_ex;
            fsm_nxt        = REDIR_PEND;
            hz.stall       = 6'b000011;
            hz.flush_if_id = 1'b1;
            hz.flush_id_ex = 1'b1;
        end else if (fsm == REDIR_PEND && hz.stallreq_if) begin
            hz.stall       = 6'b000011;
            hz.flush_if_id = 1'b1;
            hz.flush_id_ex = 1'b1;
        end else if (fsm == REDIR_PEND) begin
            hz.pc_redirect_valid = 1'b1;
            hz.pc_redirect_addr  = pend_addr;
            hz.flush_if_id       = 1'b1;
            hz.flush_id_ex       = 1'b1;
            fsm_nxt              = RUN;
        end else if (load_use) begin
            hz.stall       = 6'b000111;
            hz.flush_id_ex = 1'b1;
        end else if (hz.stallreq_if) begin
            hz.stall       = 6'b000011;
            hz.flush_if_id = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fsm       <= RUN;
            pend_addr <= 32'h0;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
        end else if (hz.rdy_in) begin
            fsm       <= fsm_nxt;
            pend_addr <= pend_nxt;
            if (hz.stallreq_mem) begin
                // saturate at the limit; with TIMEOUT_CYCLES=0 the count never leaves zero
                if (wait_cnt != LIMIT) begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if ((TIMEOUT_CYCLES != 0) && (wait_cnt + 1'b1 == LIMIT))
                        err_q <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign hz.err_timeout = err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] flush_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            flush_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (hz.flush_id_ex)
                flush_cnt_q <= flush_cnt_q + 32'd1;
            if (hz.stall[0] && hz.rdy_in)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign hz.perf_flush_cnt = flush_cnt_q;
    assign hz.perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .hz     (hz.master)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        hz.rdy_in            = 1'b1;
        hz.stallreq_if       = 1'b0;
        hz.stallreq_mem      = 1'b0;
        hz.branch_or_not_ex  = 1'b0;
        hz.branch_address_ex = 32'h0;
        hz.ld_in_ex          = 1'b0;
        hz.ld_rd_ex          = 5'd0;
        hz.id_rs1            = 5'd0;
        hz.id_rs2            = 5'd0;
        hz.id_rs1_used       = 1'b0;
        hz.id_rs2_used       = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] st, input logic fi, input logic fe,
                              input logic rv, input logic [31:0] ra);
        check({tag, ".stall"}, 64'(hz.stall), 64'(st));
        check({tag, ".flush_if_id"}, 64'(hz.flush_if_id), 64'(fi));
        check({tag, ".flush_id_ex"}, 64'(hz.flush_id_ex), 64'(fe));
        check({tag, ".redir_v"}, 64'(hz.pc_redirect_valid), 64'(rv));
        check({tag, ".redir_a"}, 64'(hz.pc_redirect_addr), 64'(ra));
    endtask

    initial begin
        idle();
        #2;
        expect_out("rst", 6'b111111, 0, 0, 0, 32'h0);
        check("rst.err", 64'(hz.err_timeout), 64'h0);
        tick();
        rst_in = 1'b1;
        tick();

        // 1: reset while a redirect to 0x1000 is pending
        hz.branch_or_not_ex = 1'b1; hz.branch_address_ex = 32'h1000; hz.stallreq_if = 1'b1;
        #1 expect_out("t1.enter", 6'b000011, 1, 1, 0, 32'h0);
        tick();
        hz.branch_or_not_ex = 1'b0;
        #1 expect_out("t1.pend", 6'b000011, 1, 1, 0, 32'h0);
        #1 rst_in = 1'b0;
        #1 expect_out("t1.inrst", 6'b111111, 0, 0, 0, 32'h0);
        hz.stallreq_if = 1'b0;
        #1 rst_in = 1'b1;
        #1 expect_out("t1.after", 6'b000000, 0, 0, 0, 32'h0);
        tick();

        // 2: plain taken branch
        hz.branch_or_not_ex = 1'b1; hz.branch_address_ex = 32'h40;
        #1 expect_out("t2", 6'b000000, 1, 1, 1, 32'h40);
        tick();
        idle();

        // 3: branch to 0x88 while IF is busy for 3 cycles
        hz.branch_or_not_ex = 1'b1; hz.branch_address_ex = 32'h88; hz.stallreq_if = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 expect_out($sformatf("t3.wait%0d", i), 6'b000011, 1, 1, 0, 32'h0);
            tick();
            hz.branch_or_not_ex = 1'b0; hz.branch_address_ex = 32'h0;
        end
        hz.stallreq_if = 1'b0;
        #1 expect_out("t3.redir", 6'b000000, 1, 1, 1, 32'h88);
        tick();
        #1 expect_out("t3.done", 6'b000000, 0, 0, 0, 32'h0);

        // 4: load-use on rs2, then rs1, then the non-hazard variants
        hz.ld_in_ex = 1'b1; hz.ld_rd_ex = 5'd5; hz.id_rs2_used = 1'b1; hz.id_rs2 = 5'd5;
        #1 expect_out("t4.rs2", 6'b000111, 0, 1, 0, 32'h0);
        tick();
        hz.ld_in_ex = 1'b0;
        #1 expect_out("t4.bubble", 6'b000000, 0, 0, 0, 32'h0);
        idle();
        hz.ld_in_ex = 1'b1; hz.ld_rd_ex = 5'd7; hz.id_rs1_used = 1'b1; hz.id_rs1 = 5'd7;
        #1 expect_out("t4.rs1", 6'b000111, 0, 1, 0, 32'h0);
        hz.id_rs1_used = 1'b0;
        #1 expect_out("t4.unused", 6'b000000, 0, 0, 0, 32'h0);
        hz.ld_rd_ex = 5'd0; hz.id_rs1 = 5'd0; hz.id_rs1_used = 1'b1;
        #1 expect_out("t4.x0", 6'b000000, 0, 0, 0, 32'h0);
        idle();
        hz.stallreq_if = 1'b1;
        #1 expect_out("t8.ifonly", 6'b000011, 1, 0, 0, 32'h0);
        idle();
        tick();

        // 5: MEM wait masks a branch; rdy low freezes everything
        hz.stallreq_mem = 1'b1; hz.branch_or_not_ex = 1'b1; hz.branch_address_ex = 32'h200;
        #1 expect_out("t5.mem0", 6'b011111, 0, 0, 0, 32'h0);
        tick();
        #1 expect_out("t5.mem1", 6'b011111, 0, 0, 0, 32'h0);
        hz.rdy_in = 1'b0; hz.stallreq_mem = 1'b0;
        #1 expect_out("t5.rdy", 6'b111111, 0, 0, 0, 32'h0);
        hz.rdy_in = 1'b1;
        #1 expect_out("t5.go", 6'b000000, 1, 1, 1, 32'h200);
        tick();
        idle();
        tick();

        // 6: watchdog with limit 4, paused by rdy low
        hz.stallreq_mem = 1'b1;
        tick(); tick();
        hz.rdy_in = 1'b0;
        tick(); tick(); tick();
        check("t6.paused", 64'(hz.err_timeout), 64'h0);
        hz.rdy_in = 1'b1;
        tick();
        check("t6.three", 64'(hz.err_timeout), 64'h0);
        tick();
        check("t6.four", 64'(hz.err_timeout), 64'h1);
        hz.stallreq_mem = 1'b0;
        tick(); tick();
        check("t6.sticky", 64'(hz.err_timeout), 64'h1);
        rst_in = 1'b0;
        #1 check("t6.rst", 64'(hz.err_timeout), 64'h0);
        rst_in = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
